// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared register offsets, CTRL bit positions, channel stride, default base address and CTRL packing for multi_timer
package multi_timer_pkg;
  localparam logic [31:0] PERI_ADDR_MULTI_TIMER = 32'hFFFF_F100;
  localparam logic [31:0] CH_STRIDE = 32'h20;
  localparam logic [2:0] OFF_CNT = 3'd0;
  localparam logic [2:0] OFF_PRESC = 3'd1;
  localparam logic [2:0] OFF_CMP = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_CAP = 3'd4;
  localparam int CTRL_EN = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLAG = 8;
  typedef struct packed {
    logic flag;
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;
  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN] = c.en;
    w[CTRL_ONESHOT] = c.oneshot;
    w[CTRL_IRQ_EN] = c.irq_en;
    w[CTRL_FLAG] = c.flag;
    return w;
  endfunction
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: peripheral bus (wen, wdata, addr, rdata) with master and slave modports
interface multi_timer_if;
  logic wen;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] rdata;
  modport master (output wen, wdata, addr, input rdata);
  modport slave (input wen, wdata, addr, output rdata);
endinterface

// File: rtl/multi_timer_channel.sv
// multi_timer_channel: one timer channel (prescaler, counter, compare, mode, sticky flag, capture under MULTI_TIMER_CAPTURE_EN); ports clk, rst, we_cnt/we_presc/we_cmp/we_ctrl, wdata, cap_in -> cnt, presc, cmp, cap, ctrl
module multi_timer_channel import multi_timer_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_cnt,
  input  logic             we_presc,
  input  logic             we_cmp,
  input  logic             we_ctrl,
  input  logic [31:0]      wdata,
  input  logic             cap_in,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] presc,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] cap,
  output ctrl_t            ctrl
);
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] wval;
  logic tick;
  logic match;
  logic w1c;
  logic unused_wdata;
  assign wval = wdata[CNT_W-1:0];
  assign tick = ctrl.en && pcnt == presc;
  assign match = tick && cnt == cmp;
  assign w1c = we_ctrl && wdata[CTRL_FLAG];
  assign unused_wdata = ^wdata;
  always_ff @(posedge clk)
    if (rst) begin
      pcnt <= '0;
      cnt <= '0;
      presc <= '0;
      cmp <= '0;
      ctrl <= '0;
    end else begin
      pcnt <= (we_presc || !ctrl.en || tick) ? '0 : pcnt + 1'b1;
      cnt <= we_cnt ? wval : !tick ? cnt : !match ? cnt + 1'b1 : ctrl.oneshot ? cnt : '0;
      presc <= we_presc ? wval : presc;
      cmp <= we_cmp ? wval : cmp;
      ctrl.en <= we_ctrl ? wdata[CTRL_EN] : ctrl.en && !(match && ctrl.oneshot);
      ctrl.oneshot <= we_ctrl ? wdata[CTRL_ONESHOT] : ctrl.oneshot;
      ctrl.irq_en <= we_ctrl ? wdata[CTRL_IRQ_EN] : ctrl.irq_en;
      ctrl.flag <= match || (ctrl.flag && !w1c);
    end
`ifdef MULTI_TIMER_CAPTURE_EN
  logic cap_q;
  always_ff @(posedge clk)
    if (rst) begin
      cap_q <= 1'b0;
      cap <= '0;
    end else begin
      cap_q <= cap_in;
      cap <= (cap_in && !cap_q) ? cnt : cap;
    end
`else
  logic unused_cap;
  assign unused_cap = cap_in;
  assign cap = '0;
`endif
endmodule

// File: rtl/multi_timer.sv
// multi_timer: memory-mapped NUM_CH-channel timer; ports clk, rst, bus (slave: wen/wdata/addr/rdata), cap_in, irq; optional capture via MULTI_TIMER_CAPTURE_EN
module multi_timer import multi_timer_pkg::*; #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = PERI_ADDR_MULTI_TIMER
) (
  input  logic              clk,
  input  logic              rst,
  multi_timer_if.slave      bus,
  input  logic [NUM_CH-1:0] cap_in,
  output logic              irq
);
  logic hit;
  logic [2:0] ch;
  logic [2:0] off;
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd;
  logic [NUM_CH-1:0] pend;
  logic unused_addr;
  assign hit = bus.addr[31:8] == BASE_ADDR[31:8];
  assign ch = bus.addr[7:5];
  assign off = bus.addr[4:2];
  assign unused_addr = ^bus.addr[1:0];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] cmp;
    logic [CNT_W-1:0] cap;
    ctrl_t ctrl;
    assign sel = bus.wen && hit && ch == 3'(i);
    multi_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .we_cnt(sel && off == OFF_CNT),
      .we_presc(sel && off == OFF_PRESC),
      .we_cmp(sel && off == OFF_CMP),
      .we_ctrl(sel && off == OFF_CTRL),
      .wdata(bus.wdata),
      .cap_in(cap_in[i]),
      .cnt(cnt),
      .presc(presc),
      .cmp(cmp),
      .cap(cap),
      .ctrl(ctrl)
    );
    assign ch_rd[i] = off == OFF_CNT ? 32'(cnt) :
                      off == OFF_PRESC ? 32'(presc) :
                      off == OFF_CMP ? 32'(cmp) :
                      off == OFF_CTRL ? ctrl_word(ctrl) :
                      off == OFF_CAP ? 32'(cap) : '0;
    assign pend[i] = ctrl.flag && ctrl.irq_en;
  end
  always_comb begin
    rd = '0;
    for (int j = 0; j < NUM_CH; j++) rd = (hit && ch == 3'(j)) ? ch_rd[j] : rd;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.rdata <= '0;
      irq <= 1'b0;
    end else begin
      bus.rdata <= rd;
      irq <= |pend;
    end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed bench for multi_timer with a per-cycle behavioural model and literal spot checks
module tb_multi_timer;
  import multi_timer_pkg::*;
  localparam int NCH = 2;
  localparam logic [31:0] BASE = 32'hFFFF_F100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] cap_in = '0;
  logic irq;
  multi_timer_if bus();
  multi_timer #(.NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cap_in(cap_in),
    .irq(irq)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  bit started = 0;
  logic [31:0] m_cnt [NCH];
  logic [31:0] m_presc [NCH];
  logic [31:0] m_cmp [NCH];
  logic [31:0] m_cap [NCH];
  logic [31:0] m_since [NCH];
  bit m_en [NCH];
  bit m_os [NCH];
  bit m_ie [NCH];
  bit m_fl [NCH];
  bit m_capq [NCH];
  logic [31:0] m_rdata;
  bit m_irq;
  function automatic logic [31:0] a_of(int c, int o);
    return BASE + CH_STRIDE * c + 4 * o;
  endfunction
  function automatic logic [31:0] m_read(logic [31:0] a);
    int c;
    int o;
    logic [31:0] v;
    c = int'(a[7:5]);
    o = int'(a[4:2]);
    v = 0;
    if (a[31:8] == BASE[31:8] && c < NCH) begin
      if (o == 0) v = m_cnt[c];
      if (o == 1) v = m_presc[c];
      if (o == 2) v = m_cmp[c];
      if (o == 3) v = {23'b0, m_fl[c], 5'b0, m_ie[c], m_os[c], m_en[c]};
`ifdef MULTI_TIMER_CAPTURE_EN
      if (o == 4) v = m_cap[c];
`endif
    end
    return v;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_presc[c] = 0; m_cmp[c] = 0; m_cap[c] = 0; m_since[c] = 0;
        m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_fl[c] = 0; m_capq[c] = 0;
      end
      m_rdata = 0;
      m_irq = 0;
    end else begin
      m_rdata = m_read(bus.addr);
      m_irq = 0;
      for (int c = 0; c < NCH; c++) m_irq = m_irq | (m_fl[c] & m_ie[c]);
      for (int c = 0; c < NCH; c++) begin
        bit wr;
        bit tick;
        bit hm;
        int o;
        wr = bus.wen && bus.addr[31:8] == BASE[31:8] && int'(bus.addr[7:5]) == c;
        o = int'(bus.addr[4:2]);
        tick = m_en[c] && m_since[c] == m_presc[c];
        hm = tick && m_cnt[c] == m_cmp[c];
`ifdef MULTI_TIMER_CAPTURE_EN
        if (cap_in[c] && !m_capq[c]) m_cap[c] = m_cnt[c];
`endif
        m_capq[c] = cap_in[c];
        m_since[c] = (tick || !m_en[c]) ? 0 : m_since[c] + 1;
        if (hm) begin
          m_fl[c] = 1;
          if (m_os[c]) m_en[c] = 0;
          else m_cnt[c] = 0;
        end else if (tick) m_cnt[c] = m_cnt[c] + 1;
        if (wr && o == 0) m_cnt[c] = bus.wdata;
        if (wr && o == 1) begin m_presc[c] = bus.wdata; m_since[c] = 0; end
        if (wr && o == 2) m_cmp[c] = bus.wdata;
        if (wr && o == 3) begin
          m_en[c] = bus.wdata[0]; m_os[c] = bus.wdata[1]; m_ie[c] = bus.wdata[2];
          if (bus.wdata[8] && !hm) m_fl[c] = 0;
        end
      end
    end
  end
  always @(negedge clk) if (started) begin
    vectors++;
    if (bus.rdata !== m_rdata) begin
      miscompares++;
      $display("FAIL rdata @%0t: got %h expected %h", $time, bus.rdata, m_rdata);
    end
    vectors++;
    if (irq !== m_irq) begin
      miscompares++;
      $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
    end
  end
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus.wen = 1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.wen = 0;
  endtask
  task automatic rd(logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    @(posedge clk); #1;
    d = bus.rdata;
  endtask
  task automatic wait_irq(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin n = k; break; end
    end
  endtask
  initial begin
    logic [31:0] v;
    int n;
    bus.wen = 0; bus.addr = 0; bus.wdata = 0;
    @(posedge clk); #1;
    started = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 2; c++)
      for (int o = 0; o < 5; o++) begin
        rd(a_of(c, o), v);
        chk($sformatf("reset_rd_ch%0d_off%0d", c, o), v, 0);
      end
    chk("reset_irq", 32'(irq), 0);
    wr(a_of(0, 1), 3); wr(a_of(0, 2), 4); wr(a_of(0, 3), 5);
    wait_irq(n);
    chk("ch0_irq_rise", n, 21);
    rd(a_of(0, 3), v);
    chk("ch0_ctrl_flag", v, 32'h105);
    rd(a_of(0, 0), v);
    chk("ch0_cnt_restart", v, 0);
    wr(a_of(0, 3), 32'h105);
    wait_irq(n);
    chk("ch0_irq_rise2", 24 + n, 41);
    wr(a_of(0, 3), 32'h100);
    wr(a_of(1, 2), 2); wr(a_of(1, 3), 7);
    wait_irq(n);
    chk("ch1_oneshot_irq", n, 4);
    rd(a_of(1, 3), v);
    chk("ch1_oneshot_ctrl", v, 32'h106);
    wr(a_of(1, 3), 32'h104);
    repeat (50) @(posedge clk);
    #1;
    rd(a_of(1, 3), v);
    chk("ch1_no_more_flags", v, 32'h004);
    rd(a_of(1, 0), v);
    chk("ch1_cnt_held", v, 2);
    wr(a_of(1, 3), 32'h100);
    wr(a_of(1, 0), 32'hFFFF_FFFE); wr(a_of(1, 2), 5); wr(a_of(1, 1), 0); wr(a_of(1, 3), 1);
    bus.addr = a_of(1, 0);
    @(posedge clk); #1;
    chk("wrap_cnt_e0", bus.rdata, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("wrap_cnt_e1", bus.rdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("wrap_cnt_e2", bus.rdata, 0);
    repeat (3) @(posedge clk);
    #1;
    rd(a_of(1, 3), v);
    chk("wrap_no_flag", v, 32'h001);
    rd(a_of(1, 3), v);
    chk("wrap_no_flag_at_cmp", v, 32'h001);
    rd(a_of(1, 3), v);
    chk("wrap_flag_at_cmp", v, 32'h101);
    wr(a_of(1, 3), 32'h100);
    wr(a_of(0, 1), 0); wr(a_of(0, 2), 3); wr(a_of(0, 0), 0); wr(a_of(0, 3), 5);
    repeat (3) @(posedge clk);
    #1;
    wr(a_of(0, 3), 32'h105);
    wr(a_of(0, 3), 32'h105);
    chk("w1c_collision_flag", bus.rdata, 32'h105);
    chk("w1c_irq_high", 32'(irq), 1);
    @(posedge clk); #1;
    chk("w1c_irq_low", 32'(irq), 0);
    chk("w1c_flag_cleared", bus.rdata, 32'h005);
    wr(a_of(0, 3), 32'h100);
    wr(a_of(0, 0), 7);
    cap_in[0] = 1;
    @(posedge clk); #1;
    cap_in[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    rd(a_of(0, 4), v);
`ifdef MULTI_TIMER_CAPTURE_EN
    chk("cap0", v, 7);
`else
    chk("cap0", v, 0);
`endif
    wr(a_of(5, 0), 123);
    rd(a_of(5, 0), v);
    chk("ch5_read", v, 0);
    rd(32'hFFFF_F200, v);
    chk("nohit_read", v, 0);
    rd(a_of(0, 6), v);
    chk("unused_off_read", v, 0);
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
